// File: rtl/byte_queue.sv
// -----------------------------------------------------------------------------
// byte_queue
//
// Byte FIFO sitting directly behind the serial deserializer. Each assembled
// byte is taken through the deserializer's four-phase data_ready/ack
// handshake. The queue stores up to DEPTH bytes and releases them in order,
// one per cycle, on a dequeue_in request. While the queue is full the
// acknowledge is withheld, which stalls the deserializer on its current byte.
//
// Optional feature macro: BYTE_QUEUE_ERR_EN
//   defined     : error_out is a sticky underflow flag (pop requested while
//                 empty); it is cleared only by reset.
//   not defined : error_out is tied to 0 and no flag register exists.
//
// Parameters
//   DEPTH  storage entries (power of two, >= 2)
//   WIDTH  byte width, matches the deserializer data_out
//
// Ports
//   clock          in   rising-edge clock, single domain
//   reset          in   asynchronous reset, active low
//   data_in        in   byte from the deserializer
//   data_ready_in  in   byte on data_in is valid while high
//   ack_out        out  byte accepted (to deserializer ack_in)
//   dequeue_in     in   pop request, sampled every cycle
//   data_out       out  last popped byte, held until the next pop
//   valid_out      out  one-cycle pulse: data_out updated this cycle
//   len_out        out  occupancy, 0..DEPTH
//   full_out       out  len_out == DEPTH
//   error_out      out  sticky underflow flag (see macro above)
//
// Every output is driven straight from a flop; nothing is combinational
// from an input.
// -----------------------------------------------------------------------------
module byte_queue #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [WIDTH-1:0]             data_in,
  input  logic                         data_ready_in,
  output logic                         ack_out,
  input  logic                         dequeue_in,
  output logic [WIDTH-1:0]             data_out,
  output logic                         valid_out,
  output logic [$clog2(DEPTH+1)-1:0]   len_out,
  output logic                         full_out,
  output logic                         error_out
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [CW-1:0] CNT_DEPTH = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [PW-1:0] PTR_ZERO  = {PW{1'b0}};
  localparam logic [PW-1:0] PTR_ONE   = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] DATA_ZERO = {WIDTH{1'b0}};

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } state_e;

  // Storage and state
  logic [WIDTH-1:0] mem_q [DEPTH];

  state_e           state_q,   state_d;
  logic [PW-1:0]    wr_ptr_q,  wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q,  rd_ptr_d;
  logic [CW-1:0]    count_q,   count_d;
  logic [WIDTH-1:0] data_q,    data_d;
  logic             valid_q,   valid_d;
  logic             ack_q,     ack_d;
  logic             full_q,    full_d;

  logic             full_s;
  logic             empty_s;
  logic             wr_en_s;
  logic             pop_s;

  // Full/empty are judged on the count held at the start of the cycle, so a
  // same-cycle pop never frees room for a write in that same cycle.
  always_comb begin
    full_s  = (count_q == CNT_DEPTH);
    empty_s = (count_q == CNT_ZERO);
  end

  // Enqueue handshake FSM: one capture per data_ready_in high period.
  always_comb begin
    state_d = state_q;
    wr_en_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (data_ready_in && !full_s) begin
          wr_en_s = 1'b1;
          state_d = ST_ACK;
        end else begin
          // Full: the deserializer keeps offering until room appears.
          state_d = ST_IDLE;
        end
      end
      ST_ACK: begin
        if (!data_ready_in) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_ACK;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Pop, pointer and occupancy next-state.
  always_comb begin
    // A pop on an empty queue is ignored even when a write lands in the same
    // cycle: the new byte does not fall through to data_out.
    pop_s    = dequeue_in && !empty_s;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    data_d   = data_q;

    if (wr_en_s) begin
      // DEPTH is a power of two, so natural pointer overflow wraps modulo DEPTH.
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
      data_d   = mem_q[rd_ptr_q];
    end else begin
      rd_ptr_d = rd_ptr_q;
      data_d   = data_q;
    end

    case ({wr_en_s, pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;  // idle, or write and pop cancel out
    endcase

    valid_d = pop_s;
    ack_d   = (state_d == ST_ACK);
    full_d  = (count_d == CNT_DEPTH);
  end

  // Control and output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      wr_ptr_q <= PTR_ZERO;
      rd_ptr_q <= PTR_ZERO;
      count_q  <= CNT_ZERO;
      data_q   <= DATA_ZERO;
      valid_q  <= 1'b0;
      ack_q    <= 1'b0;
      full_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      ack_q    <= ack_d;
      full_q   <= full_d;
    end
  end

  // Storage array; deliberately not reset, stale contents are unreachable
  // once the pointers are cleared.
  always_ff @(posedge clock) begin
    if (wr_en_s) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

`ifdef BYTE_QUEUE_ERR_EN
  logic err_q, err_d;

  // Sticky underflow: any pop request seen while empty sets the flag.
  always_comb begin
    err_d = err_q | (dequeue_in && empty_s);
  end

  // Underflow flag register, cleared only by reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign error_out = err_q;
`else
  assign error_out = 1'b0;
`endif

  assign ack_out   = ack_q;
  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign len_out   = count_q;
  assign full_out  = full_q;

endmodule

// File: tb/tb_byte_queue.sv
// -----------------------------------------------------------------------------
// tb_byte_queue
//
// Directed bench for byte_queue (DEPTH=8, WIDTH=8). Inputs change 1 time
// unit after a rising edge and outputs are sampled at that same point, so
// every sample reflects the state right after the preceding edge.
// -----------------------------------------------------------------------------
module tb_byte_queue;

  logic       clock;
  logic       reset;
  logic [7:0] data_in;
  logic       data_ready_in;
  logic       ack_out;
  logic       dequeue_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic [3:0] len_out;
  logic       full_out;
  logic       error_out;

  int n_checks;
  int n_fail;

  logic exp_err;

  byte_queue #(
    .DEPTH (8),
    .WIDTH (8)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .data_in       (data_in),
    .data_ready_in (data_ready_in),
    .ack_out       (ack_out),
    .dequeue_in    (dequeue_in),
    .data_out      (data_out),
    .valid_out     (valid_out),
    .len_out       (len_out),
    .full_out      (full_out),
    .error_out     (error_out)
  );

  // 10-unit clock
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One complete handshake: offer for one cycle, then drop and let ack fall.
  task automatic push(input logic [7:0] b);
    data_in       = b;
    data_ready_in = 1'b1;
    tick();
    data_ready_in = 1'b0;
    tick();
  endtask

  // One-cycle pop request; outputs reflect the pop on return.
  task automatic pop();
    dequeue_in = 1'b1;
    tick();
    dequeue_in = 1'b0;
  endtask

  initial begin
    logic [7:0] b;
    n_checks      = 0;
    n_fail        = 0;
    exp_err       = 1'b0;
    reset         = 1'b0;
    data_in       = 8'h00;
    data_ready_in = 1'b0;
    dequeue_in    = 1'b0;

    // ---- reset state
    tick();
    tick();
    check_eq("rst_ack",   32'(ack_out),   32'd0);
    check_eq("rst_len",   32'(len_out),   32'd0);
    check_eq("rst_full",  32'(full_out),  32'd0);
    check_eq("rst_valid", 32'(valid_out), 32'd0);
    check_eq("rst_data",  32'(data_out),  32'h00);
    check_eq("rst_err",   32'(error_out), 32'd0);
    reset = 1'b1;
    tick();

    // ---- reset in the middle of an ACK
    data_in       = 8'h33;
    data_ready_in = 1'b1;
    tick();
    check_eq("midack_ack", 32'(ack_out), 32'd1);
    check_eq("midack_len", 32'(len_out), 32'd1);
    reset = 1'b0;
    #1;
    check_eq("async_ack", 32'(ack_out), 32'd0);
    check_eq("async_len", 32'(len_out), 32'd0);
    tick();
    reset = 1'b1;
    tick();
    check_eq("recap_ack", 32'(ack_out), 32'd1);
    check_eq("recap_len", 32'(len_out), 32'd1);
    data_ready_in = 1'b0;
    tick();
    check_eq("recap_drop_ack", 32'(ack_out), 32'd0);
    pop();
    check_eq("recap_pop_data",  32'(data_out),  32'h33);
    check_eq("recap_pop_valid", 32'(valid_out), 32'd1);
    check_eq("recap_pop_len",   32'(len_out),   32'd0);
    tick();
    check_eq("valid_pulse_end", 32'(valid_out), 32'd0);

    // ---- single long handshake: one write only
    data_in       = 8'hA5;
    data_ready_in = 1'b1;
    tick();
    check_eq("hold_ack_c1", 32'(ack_out), 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("hold_ack", 32'(ack_out), 32'd1);
    end
    check_eq("hold_len", 32'(len_out), 32'd1);
    data_ready_in = 1'b0;
    tick();
    check_eq("hold_ack_fall", 32'(ack_out), 32'd0);
    check_eq("hold_len_after", 32'(len_out), 32'd1);
    pop();
    check_eq("hold_pop_data",  32'(data_out),  32'hA5);
    check_eq("hold_pop_valid", 32'(valid_out), 32'd1);
    check_eq("hold_pop_len",   32'(len_out),   32'd0);

    // ---- fill, back-pressure, pop releases room
    for (int i = 1; i <= 8; i++) begin
      push(8'(i));
    end
    check_eq("fill_len",  32'(len_out),  32'd8);
    check_eq("fill_full", 32'(full_out), 32'd1);
    data_in       = 8'h09;
    data_ready_in = 1'b1;
    tick();
    check_eq("full_noack1", 32'(ack_out), 32'd0);
    tick();
    check_eq("full_noack2", 32'(ack_out), 32'd0);
    check_eq("full_len",    32'(len_out), 32'd8);
    dequeue_in = 1'b1;
    tick();
    dequeue_in = 1'b0;
    check_eq("full_pop_data", 32'(data_out), 32'h01);
    check_eq("full_pop_ack",  32'(ack_out),  32'd0);
    check_eq("full_pop_len",  32'(len_out),  32'd7);
    check_eq("full_pop_full", 32'(full_out), 32'd0);
    tick();
    check_eq("late_ack",  32'(ack_out),  32'd1);
    check_eq("late_len",  32'(len_out),  32'd8);
    check_eq("late_full", 32'(full_out), 32'd1);
    data_ready_in = 1'b0;
    tick();
    for (int i = 2; i <= 9; i++) begin
      pop();
      check_eq("drain_data", 32'(data_out), 32'(i));
    end
    check_eq("drain_len", 32'(len_out), 32'd0);

    // ---- wrap-around: 12 push/pop pairs
    for (int i = 0; i < 12; i++) begin
      b = 8'h10 + 8'(i);
      push(b);
      pop();
      check_eq("wrap_data",  32'(data_out),  32'(b));
      check_eq("wrap_valid", 32'(valid_out), 32'd1);
    end
    check_eq("wrap_len", 32'(len_out), 32'd0);

    // ---- simultaneous write and pop at occupancy 3
    push(8'h40);
    push(8'h41);
    push(8'h42);
    check_eq("sim_len_pre", 32'(len_out), 32'd3);
    data_in       = 8'h43;
    data_ready_in = 1'b1;
    dequeue_in    = 1'b1;
    tick();
    dequeue_in = 1'b0;
    check_eq("sim_len",   32'(len_out),   32'd3);
    check_eq("sim_data",  32'(data_out),  32'h40);
    check_eq("sim_valid", 32'(valid_out), 32'd1);
    check_eq("sim_ack",   32'(ack_out),   32'd1);
    data_ready_in = 1'b0;
    tick();
    pop();
    check_eq("sim_drain1", 32'(data_out), 32'h41);
    pop();
    check_eq("sim_drain2", 32'(data_out), 32'h42);
    pop();
    check_eq("sim_drain3", 32'(data_out), 32'h43);
    check_eq("sim_len_end", 32'(len_out), 32'd0);
    check_eq("err_before_underflow", 32'(error_out), 32'd0);

    // ---- pop on empty
`ifdef BYTE_QUEUE_ERR_EN
    exp_err = 1'b1;
`endif
    pop();
    check_eq("empty_valid", 32'(valid_out), 32'd0);
    check_eq("empty_data",  32'(data_out),  32'h43);
    check_eq("empty_len",   32'(len_out),   32'd0);
    check_eq("empty_err",   32'(error_out), 32'(exp_err));
    tick();
    check_eq("empty_err_sticky", 32'(error_out), 32'(exp_err));

    // ---- pop on empty with same-cycle write: no fall-through
    data_in       = 8'h55;
    data_ready_in = 1'b1;
    dequeue_in    = 1'b1;
    tick();
    dequeue_in = 1'b0;
    check_eq("nofall_valid", 32'(valid_out), 32'd0);
    check_eq("nofall_data",  32'(data_out),  32'h43);
    check_eq("nofall_len",   32'(len_out),   32'd1);
    data_ready_in = 1'b0;
    tick();
    pop();
    check_eq("nofall_pop", 32'(data_out), 32'h55);

    // ---- reset clears the sticky flag
    reset = 1'b0;
    #1;
    check_eq("final_rst_err",  32'(error_out), 32'd0);
    check_eq("final_rst_data", 32'(data_out),  32'h00);
    tick();
    reset = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
